// File: rtl/alu_cmd_seq.sv
// -----------------------------------------------------------------------------
// alu_cmd_seq
//
// Queues ALU commands in a small FIFO and sequences them one at a time through
// an external combinational ALU. Each command is popped, its operands are
// registered onto alu_A/alu_B/alu_op, the ALU result is captured one cycle
// later into res_data (and into the accumulator), and the result is held until
// the downstream side takes it. A command with cmd_acc=1 uses the accumulator
// (the previous result) as operand A in place of cmd_a.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender keeps valid high and its payload stable until that
// edge; the receiver may drive ready regardless of valid.
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   cmd_valid     upstream command valid
//   cmd_ready     command accepted this cycle (FIFO not full, not in reset)
//   cmd_op/a/b    opcode and operands of the incoming command
//   cmd_acc       use the accumulator instead of cmd_a as operand A
//   alu_A/B/op    registered operands/opcode driven to the external ALU
//   alu_result    combinational result from the external ALU
//   res_valid     captured result valid
//   res_ready     downstream accepts the result
//   res_data      captured result
//   fifo_count    number of occupied FIFO entries
//   dbg_state     current FSM state (0 IDLE, 1 ISSUE, 2 HOLD)
// -----------------------------------------------------------------------------
module alu_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    input  logic                     cmd_acc,
    output logic [3:0]               alu_A,
    output logic [3:0]               alu_B,
    output logic [2:0]               alu_op,
    input  logic [3:0]               alu_result,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [3:0]               res_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // FIFO entry layout: {op[11:9], a[8:5], b[4:1], acc[0]}
    logic [11:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    state_t        r_state;
    logic [3:0]    r_acc;
    logic [3:0]    r_alu_a;
    logic [3:0]    r_alu_b;
    logic [2:0]    r_alu_op;
    logic          r_res_valid;
    logic [3:0]    r_res_data;

    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    logic [11:0]   w_head;
    logic [2:0]    w_head_op;
    logic [3:0]    w_head_a;
    logic [3:0]    w_head_b;
    logic          w_head_acc;

    assign cmd_ready   = (r_count != CW'(DEPTH)) && !rst;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_not_empty = (r_count != '0);

    // Popping is driven by the registered count only, so an entry written on
    // one edge is never visible to the sequencer before the following edge.
    assign w_pop = w_not_empty &&
                   ((r_state == IDLE) || ((r_state == HOLD) && res_ready));

    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_op  = w_head[11:9];
    assign w_head_a   = w_head[8:5];
    assign w_head_b   = w_head[4:1];
    assign w_head_acc = w_head[0];

    // FIFO storage carries no reset; occupancy is tracked by pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_acc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_alu_a  <= w_head_acc ? r_acc : w_head_a;
                        r_alu_b  <= w_head_b;
                        r_alu_op <= w_head_op;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The accumulator is refreshed here, before any later pop,
                    // so a chained command always sees the latest result.
                    r_res_data  <= alu_result;
                    r_acc       <= alu_result;
                    r_res_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_alu_a  <= w_head_acc ? r_acc : w_head_a;
                            r_alu_b  <= w_head_b;
                            r_alu_op <= w_head_op;
                            r_state  <= ISSUE;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign alu_A      = r_alu_a;
    assign alu_B      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign fifo_count = r_count;
    assign dbg_state  = r_state;

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter: DEPTH, default 4, number of command FIFO entries; the value SHALL be a power of two, at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: cmd_valid  input  1  upstream command is valid.
REQ-005 Port: cmd_ready  output  1  block accepts a command this cycle.
REQ-006 Port: cmd_op  input  3  ALU opcode, passed through unmodified.
REQ-007 Port: cmd_a  input  4  operand A.
REQ-008 Port: cmd_b  input  4  operand B.
REQ-009 Port: cmd_acc  input  1  when 1, use the accumulator instead of cmd_a as operand A.
REQ-010 Port: alu_A  output  4  registered operand A driven to the combinational ALU.
REQ-011 Port: alu_B  output  4  registered operand B driven to the ALU.
REQ-012 Port: alu_op  output  3  registered opcode driven to the ALU.
REQ-013 Port: alu_result  input  4  combinational ALU result.
REQ-014 Port: res_valid  output  1  captured result is valid.
REQ-015 Port: res_ready  input  1  downstream accepts the result.
REQ-016 Port: res_data  output  4  captured result.
REQ-017 Port: fifo_count  output  log2(DEPTH)+1  number of occupied FIFO entries.

Function
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; {cmd_op, cmd_a, cmd_b, cmd_acc} SHALL then be written to the FIFO tail.
REQ-019 cmd_ready SHALL be (fifo_count != DEPTH) and not rst; when the FIFO is full, the block SHALL accept no command.
REQ-020 The FIFO SHALL be first-in first-out; its pointers SHALL wrap modulo DEPTH; it SHALL provide no bypass, so a command written at edge k is poppable no earlier than edge k+1.
REQ-021 A push and a pop on the same edge SHALL leave fifo_count unchanged, with both operations taking effect.
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-023 In IDLE with fifo_count>0, the block SHALL pop the head, load alu_A (acc if cmd_acc=1, else cmd_a), alu_B and alu_op, and go to ISSUE.
REQ-024 In ISSUE, the block SHALL latch alu_result into res_data and into the accumulator, set res_valid=1, and go to HOLD unconditionally.
REQ-025 In HOLD with res_ready=0, the block SHALL hold res_valid, res_data and the alu_* outputs stable.
REQ-026 In HOLD with res_ready=1 and the FIFO non-empty, the block SHALL clear res_valid and pop/issue the next command as in REQ-023, going to ISSUE.
REQ-027 In HOLD with res_ready=1 and the FIFO empty, the block SHALL clear res_valid and go to IDLE.
REQ-028 Latency: a command accepted at edge k into an idle, empty block SHALL produce res_valid=1 after edge k+2; sustained throughput with res_ready=1 SHALL be one result per 2 cycles.
REQ-029 Because the accumulator is updated before the next pop, a chained cmd_acc=1 command SHALL always use the immediately preceding result.
REQ-030 The block SHALL perform no arithmetic; width and overflow behaviour SHALL be those of alu_result, which passes through unmodified.
REQ-031 In IDLE, the alu_* outputs SHALL retain their last values.

Reset
REQ-032 While rst=1 at a rising edge: state SHALL become IDLE; FIFO pointers and fifo_count SHALL become 0; the accumulator, res_data, alu_A, alu_B and alu_op SHALL become 0; res_valid SHALL become 0.
REQ-033 Reset asserted in any state, including mid-ISSUE or HOLD, SHALL discard all queued and in-flight commands and SHALL produce no res_valid pulse for them.
REQ-034 In the first cycle after rst deasserts, cmd_ready SHALL be 1.

Verification
REQ-035 Scenario: push op=000, a=0010, b=0011, with res_ready=1 -> res_valid=1 two edges after accept, with res_data=0101.
REQ-036 Scenario: push op=010, a=1010, b=1100 -> res_data=1000; then push op=000, acc=1, b=0001 -> alu_A=1000, res_data=1001.
REQ-037 Scenario: hold res_ready=0 and push 5 commands with DEPTH=4 -> cmd_ready drops when fifo_count=4 (4 queued plus 1 in HOLD); results then drain in order once res_ready=1.
REQ-038 Scenario: push op=000, a=1001, b=1000 -> res_data=0001 (4-bit wrap passed through from the ALU).
REQ-039 Scenario: assert rst during HOLD with 2 commands queued -> next cycle res_valid=0 and fifo_count=0; after rst deasserts, no stale result appears and a new command executes normally.
